// File: rtl/vending_machine_mc.sv
// vending_machine_mc -- multi-product, multi-denomination vending controller.
//
// Credit is kept in nickel units (nickel = 1, dime = 2, quarter = 5) and
// saturates rather than wraps: a coin that would overflow the credit counter
// is refused. A purchase subtracts the product's compile-time price and hands
// one dispense command to the dispenser. Any leftover credit, or the whole
// credit on cancel, is paid back one coin per hopper handshake. Each coin is
// the largest denomination that still fits.
//
// Optional feature macro: VENDING_MACHINE_MC_QUARTER_CHANGE_EN
//   defined   : quarters are used when paying change
//   undefined : change uses dimes and nickels only, so change_emit_quarter_r
//               stays 0. Quarter deposits are still accepted.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   client_nickel/dime/quarter    coin-deposit strobes
//   client_select, client_sel_id  purchase request and product index
//   client_cancel                 refund request
//   client_credit_r               current credit (nickel units)
//   client_busy_r                 high whenever not accepting deposits
//   client_coin_reject_r          pulse: a deposited coin was not counted
//   client_select_nack_r          pulse: selection refused
//   serve_done                    dispenser completion strobe
//   serve_emit_r, serve_id_r      dispense command and product index
//   change_done                   hopper completion strobe
//   change_emit_quarter/dime/nickel_r  coin-eject commands
// All outputs are registered.
module vending_machine_mc #(
  parameter int                          N_PROD  = 4,
  parameter int                          COUNT_W = 8,
  parameter logic [N_PROD*COUNT_W-1:0]   PRICES  = {8'd20, 8'd13, 8'd10, 8'd8},
  localparam int                         ID_W    = $clog2(N_PROD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               client_nickel,
  input  logic               client_dime,
  input  logic               client_quarter,
  input  logic               client_select,
  input  logic [ID_W-1:0]    client_sel_id,
  input  logic               client_cancel,
  output logic [COUNT_W-1:0] client_credit_r,
  output logic               client_busy_r,
  output logic               client_coin_reject_r,
  output logic               client_select_nack_r,
  input  logic               serve_done,
  output logic               serve_emit_r,
  output logic [ID_W-1:0]    serve_id_r,
  input  logic               change_done,
  output logic               change_emit_quarter_r,
  output logic               change_emit_dime_r,
  output logic               change_emit_nickel_r
);

  localparam logic [COUNT_W-1:0] VAL_N = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] VAL_D = COUNT_W'(2);
  localparam logic [COUNT_W-1:0] VAL_Q = COUNT_W'(5);

  typedef enum logic [2:0] {
    DEPOSIT,
    SERVE_EMIT,
    SERVE_WAIT,
    CHANGE_EMIT,
    CHANGE_WAIT
  } state_t;

  // Coins are carried as one-hot {quarter, dime, nickel}.
  function automatic logic [COUNT_W-1:0] coin_value(input logic [2:0] coin);
    if (coin[2]) return VAL_Q;
    if (coin[1]) return VAL_D;
    if (coin[0]) return VAL_N;
    return '0;
  endfunction

  // True when adding v to c stays within the counter range.
  function automatic logic coin_fits(input logic [COUNT_W-1:0] c,
                                     input logic [COUNT_W-1:0] v);
    logic [COUNT_W:0] sum;
    sum = {1'b0, c} + {1'b0, v};
    return !sum[COUNT_W];
  endfunction

  // Greedy change denomination for the credit still owed.
  function automatic logic [2:0] change_coin(input logic [COUNT_W-1:0] c);
`ifdef VENDING_MACHINE_MC_QUARTER_CHANGE_EN
    if (c >= VAL_Q) return 3'b100;
`endif
    if (c >= VAL_D) return 3'b010;
    return 3'b001;
  endfunction

  // Floors at zero so the credit counter can never underflow.
  function automatic logic [COUNT_W-1:0] sat_sub(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    return (a >= b) ? a - b : '0;
  endfunction

  function automatic logic [COUNT_W-1:0] price_of(input logic [ID_W-1:0] id);
    return PRICES[int'(id)*COUNT_W +: COUNT_W];
  endfunction

  state_t             state_r, state_n;
  logic [COUNT_W-1:0] credit_n;
  logic [ID_W-1:0]    serve_id_n;
  logic [2:0]         coin_hot;
  logic [2:0]         change_n;
  logic               coin_any, coin_multi, coin_ok;
  logic               sel_ok;
  logic               reject_n, nack_n, busy_n, emit_n;

  assign coin_hot   = client_quarter ? 3'b100 :
                      client_dime    ? 3'b010 :
                      client_nickel  ? 3'b001 : 3'b000;
  assign coin_any   = client_quarter | client_dime | client_nickel;
  assign coin_multi = (client_quarter & client_dime) |
                      (client_quarter & client_nickel) |
                      (client_dime & client_nickel);
  assign sel_ok     = (int'(client_sel_id) < N_PROD) &&
                      (client_credit_r >= price_of(client_sel_id));

  always_comb begin
    state_n    = state_r;
    credit_n   = client_credit_r;
    serve_id_n = serve_id_r;
    coin_ok    = 1'b0;
    nack_n     = 1'b0;
    case (state_r)
      DEPOSIT: begin
        if (client_select) begin
          if (sel_ok) begin
            state_n    = SERVE_EMIT;
            credit_n   = client_credit_r - price_of(client_sel_id);
            serve_id_n = client_sel_id;
          end else begin
            nack_n = 1'b1;
          end
        end else if (client_cancel && (client_credit_r != '0)) begin
          state_n = CHANGE_EMIT;
        end else if (coin_any &&
                     coin_fits(client_credit_r, coin_value(coin_hot))) begin
          coin_ok  = 1'b1;
          credit_n = client_credit_r + coin_value(coin_hot);
        end
      end
      SERVE_EMIT: state_n = SERVE_WAIT;
      SERVE_WAIT: begin
        if (serve_done)
          state_n = (client_credit_r == '0) ? DEPOSIT : CHANGE_EMIT;
      end
      CHANGE_EMIT: begin
        state_n  = CHANGE_WAIT;
        credit_n = sat_sub(client_credit_r,
                           coin_value(change_coin(client_credit_r)));
      end
      CHANGE_WAIT: begin
        if (change_done)
          state_n = (client_credit_r == '0) ? DEPOSIT : CHANGE_EMIT;
      end
      default: state_n = DEPOSIT;
    endcase

    if ((state_r != DEPOSIT) && client_select)
      nack_n = 1'b1;

    // Lower-priority coins in an accepted cycle are still refused.
    reject_n = coin_any && (!coin_ok || coin_multi);
    busy_n   = (state_n != DEPOSIT);
    emit_n   = (state_n == SERVE_EMIT);
    // Credit is frozen between entering CHANGE_EMIT and its exit edge, so the
    // coin picked from credit_n here matches the one deducted on exit.
    change_n = (state_n == CHANGE_EMIT) ? change_coin(credit_n) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) state_r <= DEPOSIT;
    else     state_r <= state_n;
  end

  // Registered outputs: the values seen one cycle after the deciding edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      client_credit_r       <= '0;
      client_busy_r         <= 1'b0;
      client_coin_reject_r  <= 1'b0;
      client_select_nack_r  <= 1'b0;
      serve_emit_r          <= 1'b0;
      serve_id_r            <= '0;
      change_emit_quarter_r <= 1'b0;
      change_emit_dime_r    <= 1'b0;
      change_emit_nickel_r  <= 1'b0;
    end else begin
      client_credit_r       <= credit_n;
      client_busy_r         <= busy_n;
      client_coin_reject_r  <= reject_n;
      client_select_nack_r  <= nack_n;
      serve_emit_r          <= emit_n;
      serve_id_r            <= serve_id_n;
      change_emit_quarter_r <= change_n[2];
      change_emit_dime_r    <= change_n[1];
      change_emit_nickel_r  <= change_n[0];
    end
  end

endmodule

// File: tb/tb_vending_machine_mc.sv
// Testbench for vending_machine_mc: directed scenarios plus randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_vending_machine_mc;

  localparam int N_PROD  = 4;
  localparam int COUNT_W = 8;
  localparam int ID_W    = 2;
  localparam int CMAX    = 255;

  localparam int S_SERVE = 0;
  localparam int S_Q     = 1;
  localparam int S_D     = 2;
  localparam int S_N     = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               client_nickel, client_dime, client_quarter;
  logic               client_select;
  logic [ID_W-1:0]    client_sel_id;
  logic               client_cancel;
  logic [COUNT_W-1:0] client_credit_r;
  logic               client_busy_r;
  logic               client_coin_reject_r;
  logic               client_select_nack_r;
  logic               serve_done;
  logic               serve_emit_r;
  logic [ID_W-1:0]    serve_id_r;
  logic               change_done;
  logic               change_emit_quarter_r, change_emit_dime_r, change_emit_nickel_r;

  always #5 clk = ~clk;

  vending_machine_mc dut (
    .clk                   (clk),
    .rst                   (rst),
    .client_nickel         (client_nickel),
    .client_dime           (client_dime),
    .client_quarter        (client_quarter),
    .client_select         (client_select),
    .client_sel_id         (client_sel_id),
    .client_cancel         (client_cancel),
    .client_credit_r       (client_credit_r),
    .client_busy_r         (client_busy_r),
    .client_coin_reject_r  (client_coin_reject_r),
    .client_select_nack_r  (client_select_nack_r),
    .serve_done            (serve_done),
    .serve_emit_r          (serve_emit_r),
    .serve_id_r            (serve_id_r),
    .change_done           (change_done),
    .change_emit_quarter_r (change_emit_quarter_r),
    .change_emit_dime_r    (change_emit_dime_r),
    .change_emit_nickel_r  (change_emit_nickel_r)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: an idle machine holds credit; a busy machine works
  // through a plan of steps (a serve, then change coins). Each step spends one
  // cycle being commanded, then waits for its completion strobe.
  int  price [N_PROD] = '{8, 10, 13, 20};
  int  m_credit, m_id;
  bit  m_rej, m_nack, m_waiting;
  int  plan[$];

  function automatic int step_value(input int s);
    case (s)
      S_Q:     return 5;
      S_D:     return 2;
      S_N:     return 1;
      default: return 0;
    endcase
  endfunction

  task automatic plan_change(input int amount);
    int c = amount;
    while (c > 0) begin
`ifdef VENDING_MACHINE_MC_QUARTER_CHANGE_EN
      if (c >= 5) begin plan.push_back(S_Q); c -= 5; continue; end
`endif
      if (c >= 2) begin plan.push_back(S_D); c -= 2; end
      else        begin plan.push_back(S_N); c -= 1; end
    end
  endtask

  task automatic model_step();
    int  ncoins, val, head;
    bit  acc;
    if (rst) begin
      m_credit = 0; m_id = 0; m_rej = 0; m_nack = 0; m_waiting = 0;
      plan.delete();
      return;
    end
    ncoins = int'(client_quarter) + int'(client_dime) + int'(client_nickel);
    val    = client_quarter ? 5 : client_dime ? 2 : client_nickel ? 1 : 0;
    acc    = 0;
    m_nack = 0;
    if (plan.size() == 0) begin
      if (client_select) begin
        if (int'(client_sel_id) < N_PROD && m_credit >= price[client_sel_id]) begin
          m_credit -= price[client_sel_id];
          m_id      = int'(client_sel_id);
          plan.push_back(S_SERVE);
          m_waiting = 0;
        end else begin
          m_nack = 1;
        end
      end else if (client_cancel && m_credit > 0) begin
        plan_change(m_credit);
        m_waiting = 0;
      end else if (ncoins > 0 && m_credit + val <= CMAX) begin
        acc = 1;
        m_credit += val;
      end
    end else begin
      if (client_select) m_nack = 1;
      head = plan[0];
      if (!m_waiting) begin
        m_credit -= step_value(head);
        m_waiting = 1;
      end else if ((head == S_SERVE) ? serve_done : change_done) begin
        void'(plan.pop_front());
        m_waiting = 0;
        if (head == S_SERVE && m_credit > 0) plan_change(m_credit);
      end
    end
    m_rej = (ncoins > 0) && (!acc || ncoins > 1);
  endtask

  function automatic bit m_cmd(input int s);
    return plan.size() > 0 && !m_waiting && plan[0] == s;
  endfunction

  task automatic compare_all();
    check("credit",     32'(client_credit_r),       32'(m_credit));
    check("busy",       32'(client_busy_r),         32'(plan.size() > 0));
    check("coin_rej",   32'(client_coin_reject_r),  32'(m_rej));
    check("sel_nack",   32'(client_select_nack_r),  32'(m_nack));
    check("serve_emit", 32'(serve_emit_r),          32'(m_cmd(S_SERVE)));
    check("serve_id",   32'(serve_id_r),            32'(m_id));
    check("chg_q",      32'(change_emit_quarter_r), 32'(m_cmd(S_Q)));
    check("chg_d",      32'(change_emit_dime_r),    32'(m_cmd(S_D)));
    check("chg_n",      32'(change_emit_nickel_r),  32'(m_cmd(S_N)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    client_nickel = 0; client_dime = 0; client_quarter = 0;
    client_select = 0; client_sel_id = '0; client_cancel = 0;
    serve_done = 0; change_done = 0;
  endtask

  // One cycle with the given strobes, then back to idle inputs.
  task automatic step(input bit q, input bit d, input bit n, input bit sel,
                      input int id, input bit can, input bit sd, input bit cd);
    client_quarter = q; client_dime = d; client_nickel = n;
    client_select = sel; client_sel_id = ID_W'(id); client_cancel = can;
    serve_done = sd; change_done = cd;
    tick();
    idle_inputs();
  endtask

  int nq, nd, nn;

  // Acknowledge every serve/change until the machine is idle, counting coins.
  task automatic drain();
    bit done = 0;
    nq = 0; nd = 0; nn = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      serve_done = 1; change_done = 1;
      tick();
      nq += int'(change_emit_quarter_r);
      nd += int'(change_emit_dime_r);
      nn += int'(change_emit_nickel_r);
      if (!client_busy_r) done = 1;
    end
    idle_inputs();
    if (!done) check("drain_timeout", 32'(client_busy_r), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    check("rst_credit", 32'(client_credit_r), 32'd0);
    check("rst_busy",   32'(client_busy_r),   32'd0);
    check("rst_id",     32'(serve_id_r),      32'd0);
    rst = 0;

    // Exact-price purchase, no change.
    step(1,0,0, 0,0, 0,0,0);
    step(0,1,0, 0,0, 0,0,0);
    step(0,0,1, 0,0, 0,0,0);
    check("t1_credit", 32'(client_credit_r), 32'd8);
    step(0,0,0, 1,0, 0,0,0);
    check("t1_emit",   32'(serve_emit_r),    32'd1);
    check("t1_id",     32'(serve_id_r),      32'd0);
    check("t1_credit0",32'(client_credit_r), 32'd0);
    step(0,0,0, 0,0, 0,0,0);
    check("t1_emit_off", 32'(serve_emit_r),  32'd0);
    check("t1_wait_busy",32'(client_busy_r), 32'd1);
    step(0,0,0, 0,0, 0,1,0);
    check("t1_idle", 32'(client_busy_r), 32'd0);
    check("t1_nochg", 32'({change_emit_quarter_r, change_emit_dime_r, change_emit_nickel_r}), 32'd0);

    // Overpay and receive greedy change.
    repeat (3) step(1,0,0, 0,0, 0,0,0);
    check("t2_credit", 32'(client_credit_r), 32'd15);
    step(0,0,0, 1,0, 0,0,0);
    check("t2_after_buy", 32'(client_credit_r), 32'd7);
    step(0,0,0, 0,0, 0,0,0);
    drain();
`ifdef VENDING_MACHINE_MC_QUARTER_CHANGE_EN
    check("t2_nq", 32'(nq), 32'd1);
    check("t2_nd", 32'(nd), 32'd1);
    check("t2_nn", 32'(nn), 32'd0);
`else
    check("t2_nq", 32'(nq), 32'd0);
    check("t2_nd", 32'(nd), 32'd3);
    check("t2_nn", 32'(nn), 32'd1);
`endif
    check("t2_credit0", 32'(client_credit_r), 32'd0);

    // Refused selection, then cancel refund.
    step(0,1,0, 0,0, 0,0,0);
    step(0,0,0, 1,3, 0,0,0);
    check("t3_nack",   32'(client_select_nack_r), 32'd1);
    check("t3_credit", 32'(client_credit_r),      32'd2);
    step(0,0,0, 0,0, 0,0,0);
    check("t3_nack_pulse", 32'(client_select_nack_r), 32'd0);
    step(0,0,0, 0,0, 1,0,0);
    check("t3_chg_d", 32'(change_emit_dime_r), 32'd1);
    drain();
    check("t3_idle", 32'(client_busy_r), 32'd0);

    // Coin while busy, then two coins in one deposit cycle.
    step(1,0,0, 0,0, 0,0,0);
    step(1,0,0, 0,0, 0,0,0);
    step(0,0,0, 1,0, 0,0,0);
    step(0,0,0, 0,0, 0,0,0);
    step(0,0,1, 0,0, 0,0,0);
    check("t4_busy_rej",    32'(client_coin_reject_r), 32'd1);
    check("t4_busy_credit", 32'(client_credit_r),      32'd2);
    drain();
    step(1,0,1, 0,0, 0,0,0);
    check("t4_dual_credit", 32'(client_credit_r),      32'd5);
    check("t4_dual_rej",    32'(client_coin_reject_r), 32'd1);
    step(0,0,0, 0,0, 1,0,0);
    drain();

    // Saturation at the top of the credit range.
    repeat (51) step(1,0,0, 0,0, 0,0,0);
    check("t5_full", 32'(client_credit_r), 32'd255);
    step(0,0,1, 0,0, 0,0,0);
    check("t5_rej",    32'(client_coin_reject_r), 32'd1);
    check("t5_credit", 32'(client_credit_r),      32'd255);
    step(0,0,0, 0,0, 1,0,0);
    drain();
    check("t5_credit0", 32'(client_credit_r), 32'd0);

    // Reset while waiting on the hopper with credit 3 still owed.
`ifdef VENDING_MACHINE_MC_QUARTER_CHANGE_EN
    step(1,0,0, 0,0, 0,0,0);
    step(0,1,0, 0,0, 0,0,0);
    step(0,0,1, 0,0, 0,0,0);
`else
    step(1,0,0, 0,0, 0,0,0);
`endif
    step(0,0,0, 0,0, 1,0,0);
    step(0,0,0, 0,0, 0,0,0);
    check("t6_pre_credit", 32'(client_credit_r), 32'd3);
    check("t6_pre_busy",   32'(client_busy_r),   32'd1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_credit", 32'(client_credit_r), 32'd0);
    check("t6_outs", 32'({client_busy_r, client_coin_reject_r, client_select_nack_r,
                          serve_emit_r, serve_id_r, change_emit_quarter_r,
                          change_emit_dime_r, change_emit_nickel_r}), 32'd0);
    step(0,0,0, 0,0, 0,0,1);
    check("t6_late_done", 32'({client_busy_r, change_emit_quarter_r,
                               change_emit_dime_r, change_emit_nickel_r}), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 249) == 0);
      client_quarter = ($urandom_range(0, 99) < 12);
      client_dime    = ($urandom_range(0, 99) < 12);
      client_nickel  = ($urandom_range(0, 99) < 12);
      client_select  = ($urandom_range(0, 99) < 10);
      client_sel_id  = ID_W'($urandom_range(0, N_PROD - 1));
      client_cancel  = ($urandom_range(0, 99) < 4);
      serve_done     = ($urandom_range(0, 99) < 35);
      change_done    = ($urandom_range(0, 99) < 35);
      tick();
    end
    rst = 0;
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
